// File: rtl/mem_stage_pipelined.sv
// mem_stage_pipelined: handshaked memory-access stage between EX and WB.
// Holds one instruction, issues a multi-cycle data-cache request, then
// extracts/extends load data, and presents the result to WB.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned or
// illegal-size accesses instead of aligning them down.
module mem_stage_pipelined #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_read,
    input  logic                    in_write,
    input  logic [2:0]              in_funct3,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    input  logic [4:0]              in_rd,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    input  logic                    flush,
    output logic [ADDR_WIDTH-1:0]   data_addr,
    output logic                    data_read,
    output logic                    data_write,
    output logic [DATA_WIDTH/8-1:0] data_mbe,
    output logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic [DATA_WIDTH-1:0]   data_rdata,
    input  logic                    data_resp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [4:0]              out_rd,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic                    out_trap
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFS   = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state, state_nxt;
    logic                kill;
    logic [1:0]          r_size;
    logic [OFS-1:0]      r_ofs;
    logic                r_zext;
    logic                r_load;

    logic [1:0]          size_c, eff_size_c;
    logic [OFS-1:0]      ofs_c, eff_ofs_c, low_mask_c;
    logic                illegal_c, misaligned_c, trap_c, mem_op_c;
    logic                accept_c, go_req_c;
    logic [7:0]          base_mask_c;
    logic [DATA_WIDTH-1:0] sh_c, mask_c, ext_c;
    logic                sign_c;

    assign in_ready = (state == IDLE);

    // Decode size, alignment and trap condition of the incoming instruction
    always_comb begin
        size_c       = in_funct3[1:0];
        ofs_c        = in_addr[OFS-1:0];
        illegal_c    = (size_c == 2'd3) && (DATA_WIDTH != 64);
        eff_size_c   = illegal_c ? 2'd2 : size_c;
        low_mask_c   = OFS'(4'(4'd1 << eff_size_c) - 4'd1);
        misaligned_c = (ofs_c & low_mask_c) != '0;
        mem_op_c     = in_read | in_write;
`ifdef MEM_MISALIGN_TRAP_EN
        trap_c       = mem_op_c && (illegal_c || misaligned_c);
        eff_ofs_c    = ofs_c;
`else
        trap_c       = 1'b0;
        eff_ofs_c    = misaligned_c ? (ofs_c & ~low_mask_c) : ofs_c;
`endif
        accept_c     = (state == IDLE) && in_valid && !flush;
        go_req_c     = mem_op_c && !trap_c;
        case (eff_size_c)
            2'd0:    base_mask_c = 8'h01;
            2'd1:    base_mask_c = 8'h03;
            2'd2:    base_mask_c = 8'h0F;
            default: base_mask_c = 8'hFF;
        endcase
    end

    // Shift the addressed lanes down and sign/zero-extend to the data width
    always_comb begin
        sh_c = data_rdata >> {r_ofs, 3'b000};
        case (r_size)
            2'd0:    begin mask_c = DATA_WIDTH'(8'hFF);         sign_c = sh_c[7];  end
            2'd1:    begin mask_c = DATA_WIDTH'(16'hFFFF);      sign_c = sh_c[15]; end
            2'd2:    begin mask_c = DATA_WIDTH'(32'hFFFF_FFFF); sign_c = sh_c[31]; end
            default: begin mask_c = '1;                         sign_c = sh_c[DATA_WIDTH-1]; end
        endcase
        ext_c = (sh_c & mask_c) | ((sign_c && !r_zext) ? ~mask_c : '0);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_c) state_nxt = go_req_c ? REQ : DONE;
            REQ:  if (data_resp) state_nxt = (kill || flush) ? IDLE : DONE;
            DONE: if (flush || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, result-valid and sticky kill registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            kill      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == DONE);
            kill      <= (state == REQ) && !data_resp && (kill || flush);
        end
    end

    // Capture the instruction on accept, drop strobes and load data on resp
    always_ff @(posedge clk) begin
        if (rst) begin
            data_read  <= 1'b0;
            data_write <= 1'b0;
            data_addr  <= '0;
            data_mbe   <= '0;
            data_wdata <= '0;
            out_data   <= '0;
            out_rd     <= '0;
            out_pc     <= '0;
            out_trap   <= 1'b0;
            r_size     <= '0;
            r_ofs      <= '0;
            r_zext     <= 1'b0;
            r_load     <= 1'b0;
        end else if (accept_c) begin
            out_rd     <= in_rd;
            out_pc     <= in_pc;
            out_data   <= DATA_WIDTH'(in_addr);
            out_trap   <= trap_c;
            r_size     <= eff_size_c;
            r_ofs      <= eff_ofs_c;
            r_zext     <= in_funct3[2];
            r_load     <= in_read;
            data_read  <= in_read && go_req_c;
            data_write <= in_write && go_req_c;
            if (go_req_c) begin
                data_addr  <= {in_addr[ADDR_WIDTH-1:OFS], OFS'(0)};
                data_mbe   <= BYTES'(base_mask_c) << eff_ofs_c;
                data_wdata <= in_wdata << {eff_ofs_c, 3'b000};
            end
        end else if ((state == REQ) && data_resp) begin
            data_read  <= 1'b0;
            data_write <= 1'b0;
            if (r_load) out_data <= ext_c;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Directed bench for mem_stage_pipelined: a 32-bit and a 64-bit instance.
module tb_mem_stage_pipelined;
    logic clk, rst;

    // 32-bit instance signals
    logic        in_valid, in_ready, in_read, in_write, flush;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata, in_pc, data_addr, data_wdata, data_rdata, out_data, out_pc;
    logic [4:0]  in_rd, out_rd;
    logic        data_read, data_write, data_resp, out_valid, out_ready, out_trap;
    logic [3:0]  data_mbe;

    // 64-bit instance signals
    logic        d64_in_valid, d64_in_ready, d64_in_read, d64_in_write, d64_flush;
    logic [2:0]  d64_in_funct3;
    logic [31:0] d64_in_addr, d64_in_pc, d64_data_addr, d64_out_pc;
    logic [63:0] d64_in_wdata, d64_data_wdata, d64_data_rdata, d64_out_data;
    logic [4:0]  d64_in_rd, d64_out_rd;
    logic        d64_data_read, d64_data_write, d64_data_resp, d64_out_valid, d64_out_ready, d64_out_trap;
    logic [7:0]  d64_data_mbe;

    int checks = 0;
    int errors = 0;
    logic [31:0] held;

    mem_stage_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_read(in_read), .in_write(in_write),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .in_pc(in_pc), .flush(flush),
        .data_addr(data_addr), .data_read(data_read), .data_write(data_write),
        .data_mbe(data_mbe), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_resp(data_resp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_pc(out_pc), .out_trap(out_trap)
    );

    mem_stage_pipelined #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(d64_in_valid), .in_ready(d64_in_ready), .in_read(d64_in_read),
        .in_write(d64_in_write), .in_funct3(d64_in_funct3), .in_addr(d64_in_addr),
        .in_wdata(d64_in_wdata), .in_rd(d64_in_rd), .in_pc(d64_in_pc), .flush(d64_flush),
        .data_addr(d64_data_addr), .data_read(d64_data_read), .data_write(d64_data_write),
        .data_mbe(d64_data_mbe), .data_wdata(d64_data_wdata), .data_rdata(d64_data_rdata),
        .data_resp(d64_data_resp),
        .out_valid(d64_out_valid), .out_ready(d64_out_ready), .out_data(d64_out_data),
        .out_rd(d64_out_rd), .out_pc(d64_out_pc), .out_trap(d64_out_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for drive/sample
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue32(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        in_valid  = 1'b1;
        in_read   = rd_op;
        in_write  = wr_op;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wd;
        in_rd     = 5'd7;
        in_pc     = addr + 32'h1000;
        step();
        in_valid  = 1'b0;
        in_read   = 1'b0;
        in_write  = 1'b0;
    endtask

    task automatic resp32(input logic [31:0] rdata);
        data_rdata = rdata;
        data_resp  = 1'b1;
        step();
        data_resp  = 1'b0;
    endtask

    task automatic release32();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("rel_valid", out_valid, 0);
        check("rel_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        {in_valid, in_read, in_write, flush, data_resp, out_ready} = '0;
        in_funct3 = '0; in_addr = '0; in_wdata = '0; in_pc = '0; in_rd = '0; data_rdata = '0;
        {d64_in_valid, d64_in_read, d64_in_write, d64_flush, d64_data_resp, d64_out_ready} = '0;
        d64_in_funct3 = '0; d64_in_addr = '0; d64_in_wdata = '0; d64_in_pc = '0;
        d64_in_rd = '0; d64_data_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_rd", data_read, 0);
        check("rst_wr", data_write, 0);
        check("rst_mbe", data_mbe, 0);
        check("rst_addr", data_addr, 0);
        check("rst_odata", out_data, 0);
        check("rst_trap", out_trap, 0);

        // LB at 0x103, byte 0x80 sign-extended, 1-cycle cache
        issue32(1, 0, 3'b000, 32'h0000_0103, 32'h0);
        check("lb_read", data_read, 1);
        check("lb_addr", data_addr, 32'h100);
        check("lb_mbe", data_mbe, 4'h8);
        check("lb_ready", in_ready, 0);
        check("lb_novalid", out_valid, 0);
        resp32(32'h80FF_0000);
        check("lb_valid", out_valid, 1);
        check("lb_data", out_data, 32'hFFFF_FF80);
        check("lb_rdreg", out_rd, 5'd7);
        check("lb_pc", out_pc, 32'h0000_1103);
        check("lb_strobe_off", data_read, 0);
        release32();

        // LHU at 0x202, response delayed 3 cycles
        issue32(1, 0, 3'b101, 32'h0000_0202, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("lhu_read", data_read, 1);
            check("lhu_addr", data_addr, 32'h200);
            check("lhu_mbe", data_mbe, 4'hC);
            check("lhu_ready", in_ready, 0);
            check("lhu_novalid", out_valid, 0);
            step();
        end
        resp32(32'hBEEF_1234);
        check("lhu_valid", out_valid, 1);
        check("lhu_data", out_data, 32'h0000_BEEF);
        release32();

        // LH at 0x200, sign-extend halfword
        issue32(1, 0, 3'b001, 32'h0000_0200, 32'h0);
        check("lh_mbe", data_mbe, 4'h3);
        resp32(32'h0000_8001);
        check("lh_data", out_data, 32'hFFFF_8001);
        release32();

        // SB at 0x301
        issue32(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00AB);
        check("sb_write", data_write, 1);
        check("sb_read", data_read, 0);
        check("sb_mbe", data_mbe, 4'h2);
        check("sb_wdata", data_wdata, 32'h0000_AB00);
        check("sb_addr", data_addr, 32'h300);
        resp32(32'h0);
        check("sb_valid", out_valid, 1);
        check("sb_trap", out_trap, 0);
        check("sb_wr_off", data_write, 0);
        release32();

        // LW at 0x402, misaligned word
        issue32(1, 0, 3'b010, 32'h0000_0402, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_read", data_read, 0);
        check("mis_valid", out_valid, 1);
        check("mis_trap", out_trap, 1);
        check("mis_data", out_data, 32'h0000_0402);
`else
        check("mis_read", data_read, 1);
        check("mis_addr", data_addr, 32'h400);
        check("mis_mbe", data_mbe, 4'hF);
        resp32(32'h1122_3344);
        check("mis_valid", out_valid, 1);
        check("mis_trap", out_trap, 0);
        check("mis_data", out_data, 32'h1122_3344);
`endif
        release32();

        // Pass-through, held with out_ready low
        issue32(0, 0, 3'b010, 32'h1234_5678, 32'h0);
        held = out_data;
        check("pt_data", held, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            check("pt_valid", out_valid, 1);
            check("pt_hold", out_data, held);
            check("pt_ready", in_ready, 0);
            check("pt_nostrobe", {data_read, data_write}, 2'b00);
            step();
        end
        release32();

        // Flush while in REQ: request held until resp, result dropped
        issue32(1, 0, 3'b010, 32'h0000_0500, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_req_held1", data_read, 1);
        step();
        check("fl_req_held2", data_read, 1);
        check("fl_novalid", out_valid, 0);
        resp32(32'hDEAD_BEEF);
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_strobe", data_read, 0);

        // Flush in DONE drops the result
        issue32(0, 0, 3'b000, 32'h0000_0600, 32'h0);
        check("fd_valid", out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fd_dropped", out_valid, 0);
        check("fd_ready", in_ready, 1);

        // Flush with in_valid in IDLE: not accepted; resp in IDLE ignored
        in_valid = 1'b1; flush = 1'b1; data_resp = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0; data_resp = 1'b0;
        check("fi_ready", in_ready, 1);
        check("fi_valid", out_valid, 0);
        check("fi_strobe", data_read, 0);

        // 64-bit LD at 0x8, out_ready low 4 cycles
        d64_in_valid = 1'b1; d64_in_read = 1'b1; d64_in_funct3 = 3'b011;
        d64_in_addr = 32'h8; d64_in_rd = 5'd9; d64_in_pc = 32'h40;
        step();
        d64_in_valid = 1'b0; d64_in_read = 1'b0;
        check("ld_read", d64_data_read, 1);
        check("ld_addr", d64_data_addr, 32'h8);
        check("ld_mbe", d64_data_mbe, 8'hFF);
        d64_data_rdata = 64'h0123_4567_89AB_CDEF; d64_data_resp = 1'b1;
        step();
        d64_data_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ld_valid", d64_out_valid, 1);
            check("ld_data", d64_out_data, 64'h0123_4567_89AB_CDEF);
            check("ld_ready", d64_in_ready, 0);
            step();
        end
        d64_out_ready = 1'b1;
        step();
        d64_out_ready = 1'b0;
        check("ld_rel", d64_out_valid, 0);

        // 64-bit LWU at 0x4, upper word zero-extended
        d64_in_valid = 1'b1; d64_in_read = 1'b1; d64_in_funct3 = 3'b110; d64_in_addr = 32'h4;
        step();
        d64_in_valid = 1'b0; d64_in_read = 1'b0;
        check("lwu_mbe", d64_data_mbe, 8'hF0);
        check("lwu_addr", d64_data_addr, 32'h0);
        d64_data_rdata = 64'h8000_0000_0000_0000; d64_data_resp = 1'b1;
        step();
        d64_data_resp = 1'b0;
        check("lwu_data", d64_out_data, 64'h0000_0000_8000_0000);
        d64_out_ready = 1'b1;
        step();
        d64_out_ready = 1'b0;

        // Reset mid-REQ abandons the request
        d64_in_valid = 1'b1; d64_in_read = 1'b1; d64_in_funct3 = 3'b011; d64_in_addr = 32'h10;
        step();
        d64_in_valid = 1'b0; d64_in_read = 1'b0;
        check("rq_read", d64_data_read, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rq_strobe", d64_data_read, 0);
        check("rq_ready", d64_in_ready, 1);
        check("rq_valid", d64_out_valid, 0);
        check("rq_mbe", d64_data_mbe, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
